// File: rtl/usb_reset_gen.sv
// usb_reset_gen: HPI reset source for the CY7C67300. Debounces the raw centre
// button and turns each press into a timed reset pulse followed by a wake-up
// wait, then flags when the chip may be accessed over HPI.
// Optional build macro: USB_RESET_AUTO_POR_EN (issue one reset pulse right
// after sys_reset deasserts, without waiting for a button press).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_POR   | sys_reset just released; decides between IDLE and HOLD
// ST_IDLE  | chip released, never woken yet, usb_ready low
// ST_HOLD  | usb_hpi_reset_n driven low for RESET_CYCLES
// ST_WAIT  | reset released, waiting WAKE_CYCLES for the chip to boot
// ST_READY | chip accessible over HPI
module usb_reset_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_CYCLES    = 1000,
  parameter int WAKE_CYCLES     = 100000,
  parameter int CNT_W           = 24
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       button_in,
  output logic       usb_hpi_reset_n,
  output logic       usb_ready,
  output logic       busy_led,
  output logic [7:0] reset_count
);

  localparam logic [2:0] ST_POR   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  // Timers are down-counters loaded with N-1 so a phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DEB_TC     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_lvl;
  logic             stable_lvl;
  logic             stable_d;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] tmr_nxt;
  logic             enter_hold;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= button_in;
      sync_lvl  <= sync_meta;
    end
  end

  // Debouncer: accept a new level only after it has been seen DEBOUNCE_CYCLES in a row.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      stable_lvl <= 1'b0;
      stable_d   <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      stable_d <= stable_lvl;
      if (sync_lvl == stable_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        stable_lvl <= sync_lvl;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // One press per debounced rising edge; release produces nothing.
  assign press = stable_lvl & ~stable_d;

  // Next-state logic; a press in any running state restarts a full reset pulse.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    enter_hold = 1'b0;
    case (state)
      ST_POR: begin
`ifdef USB_RESET_AUTO_POR_EN
        state_nxt  = ST_HOLD;
        tmr_nxt    = RESET_LOAD;
        enter_hold = 1'b1;
`else
        state_nxt  = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        if (tmr == '0) begin
          state_nxt = ST_WAIT;
          tmr_nxt   = WAKE_LOAD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_WAIT: begin
        if (tmr == '0) begin
          state_nxt = ST_READY;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_IDLE, ST_READY: begin
        state_nxt = state;
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_nxt   = '0;
      end
    endcase
    if (press && (state != ST_POR)) begin
      state_nxt  = ST_HOLD;
      tmr_nxt    = RESET_LOAD;
      enter_hold = 1'b1;
    end
  end

  // State, timer and outputs registered together so outputs follow the new state.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state           <= ST_POR;
      tmr             <= '0;
      usb_hpi_reset_n <= 1'b0;
      usb_ready       <= 1'b0;
      busy_led        <= 1'b0;
      reset_count     <= 8'd0;
    end else begin
      state           <= state_nxt;
      tmr             <= tmr_nxt;
      usb_hpi_reset_n <= (state_nxt != ST_HOLD);
      usb_ready       <= (state_nxt == ST_READY);
      busy_led        <= (state_nxt == ST_HOLD) || (state_nxt == ST_WAIT);
      if (enter_hold) begin
        reset_count <= reset_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_reset_gen.sv
// Bench for usb_reset_gen: a vector table applied in a loop for the main
// sequence, plus hand-written sequences for restart and wrap corner cases.
// A second instance with a short debounce reaches a press inside WAIT.
module tb_usb_reset_gen;

`ifdef USB_RESET_AUTO_POR_EN
  localparam int POR_CNT   = 1;
  localparam bit POR_READY = 1'b1;
`else
  localparam int POR_CNT   = 0;
  localparam bit POR_READY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       rstn, rdy, busy;
  logic [7:0] cnt;

  logic       rst_f = 1'b1;
  logic       btn_f = 1'b0;
  logic       rstn_f, rdy_f, busy_f;
  logic [7:0] cnt_f;

  usb_reset_gen #(.DEBOUNCE_CYCLES(8), .RESET_CYCLES(5), .WAKE_CYCLES(10), .CNT_W(24)) dut (
    .sys_clk(clk), .sys_reset(rst), .button_in(btn),
    .usb_hpi_reset_n(rstn), .usb_ready(rdy), .busy_led(busy), .reset_count(cnt));

  usb_reset_gen #(.DEBOUNCE_CYCLES(2), .RESET_CYCLES(5), .WAKE_CYCLES(10), .CNT_W(24)) u_fast (
    .sys_clk(clk), .sys_reset(rst_f), .button_in(btn_f),
    .usb_hpi_reset_n(rstn_f), .usb_ready(rdy_f), .busy_led(busy_f), .reset_count(cnt_f));

  typedef struct packed {
    logic       rstn;
    logic       ready;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    string name;
    logic  rst;
    logic  btn;
    int    cycles;
    exp_t  e;
  } vec_t;

  exp_t  sb_q[$];
  string name_q[$];
  vec_t  vecs[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mke(input bit r_n, input bit ry, input bit bz, input int c);
    exp_t e;
    e.rstn  = r_n;
    e.ready = ry;
    e.busy  = bz;
    e.cnt   = 8'(c);
    return e;
  endfunction

  function automatic vec_t mk(input string nm, input bit r, input bit b, input int cyc,
                              input bit r_n, input bit ry, input bit bz, input int c);
    vec_t v;
    v.name   = nm;
    v.rst    = r;
    v.btn    = b;
    v.cycles = cyc;
    v.e      = mke(r_n, ry, bz, c);
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push_exp(input string nm, input exp_t e);
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_out(input bit fast);
    exp_t  e;
    exp_t  got;
    string nm;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got nothing queued, required one expectation");
      return;
    end
    e   = sb_q.pop_front();
    nm  = name_q.pop_front();
    got = fast ? {rstn_f, rdy_f, busy_f, cnt_f} : {rstn, rdy, busy, cnt};
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got rstn=%b ready=%b busy=%b cnt=%0d, required rstn=%b ready=%b busy=%b cnt=%0d",
               nm, got.rstn, got.ready, got.busy, got.cnt, e.rstn, e.ready, e.busy, e.cnt);
    end
  endtask

  task automatic expect_main(input string nm, input exp_t e);
    push_exp(nm, e);
    check_out(1'b0);
  endtask

  task automatic expect_fast(input string nm, input exp_t e);
    push_exp(nm, e);
    check_out(1'b1);
  endtask

  initial begin
    // name, sys_reset, button, cycles, then expected rstn, ready, busy, count
    vecs.push_back(mk("reset_state", 1, 0, 3, 0, 0, 0, 0));
`ifdef USB_RESET_AUTO_POR_EN
    vecs.push_back(mk("por_hold_first", 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("por_hold_last", 0, 0, 4, 0, 0, 1, 1));
    vecs.push_back(mk("por_wait_first", 0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk("por_wait_last", 0, 0, 9, 1, 0, 1, 1));
    vecs.push_back(mk("por_ready", 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk("ready_steady", 0, 0, 50, 1, 1, 0, 1));
`else
    vecs.push_back(mk("idle_first", 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("idle_100", 0, 0, 99, 1, 0, 0, 0));
    vecs.push_back(mk("first_pre", 0, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk("first_hold_first", 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk("first_hold_last", 0, 1, 4, 0, 0, 1, 1));
    vecs.push_back(mk("first_wait_first", 0, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk("first_wait_last", 0, 1, 9, 1, 0, 1, 1));
    vecs.push_back(mk("first_ready", 0, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk("first_release", 0, 0, 40, 1, 1, 0, 1));
`endif
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("bounce", 0, (i % 2) == 0, 3, 1, 1, 0, 1));
    vecs.push_back(mk("bounce_settle", 0, 0, 20, 1, 1, 0, 1));
    vecs.push_back(mk("clean_pre", 0, 1, 10, 1, 1, 0, 1));
    vecs.push_back(mk("clean_hold_first", 0, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk("clean_hold_last", 0, 1, 4, 0, 0, 1, 2));
    vecs.push_back(mk("clean_wait_first", 0, 1, 1, 1, 0, 1, 2));
    vecs.push_back(mk("clean_wait_last", 0, 1, 9, 1, 0, 1, 2));
    vecs.push_back(mk("clean_ready", 0, 1, 1, 1, 1, 0, 2));
    vecs.push_back(mk("clean_held", 0, 1, 14, 1, 1, 0, 2));
    vecs.push_back(mk("clean_release", 0, 0, 40, 1, 1, 0, 2));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      btn = vecs[i].btn;
      push_exp(vecs[i].name, vecs[i].e);
      step(vecs[i].cycles);
      check_out(1'b0);
    end

    // sys_reset for one cycle in the middle of a HOLD pulse
    btn = 1'b1;
    step(11);
    expect_main("mid_press_hold", mke(0, 0, 1, 3));
    step(2);
    rst = 1'b1;
    btn = 1'b0;
    step(1);
    expect_main("mid_reset", mke(0, 0, 0, 0));
    rst = 1'b0;
    step(1);
`ifdef USB_RESET_AUTO_POR_EN
    expect_main("after_mid_reset", mke(0, 0, 1, 1));
`else
    expect_main("after_mid_reset", mke(1, 0, 0, 0));
`endif
    step(30);

    // 256 presses: reset_count wraps back to its post-reset value
    for (int n = 1; n <= 256; n++) begin
      btn = 1'b1;
      step(12);
      btn = 1'b0;
      step(12);
      if (n == 255) expect_main("wrap_255", mke(1, 0, 1, POR_CNT + 255));
    end
    expect_main("wrap_256", mke(1, 0, 1, POR_CNT));

    // Fast-debounce instance: second press lands 3 cycles into WAIT
    rst_f = 1'b0;
    step(30);
    expect_fast("fast_start", mke(1, POR_READY, 0, POR_CNT));
    btn_f = 1'b1;
    step(4);
    btn_f = 1'b0;
    step(1);
    expect_fast("fast_hold", mke(0, 0, 1, POR_CNT + 1));
    step(3);
    btn_f = 1'b1;
    step(2);
    expect_fast("fast_wait_first", mke(1, 0, 1, POR_CNT + 1));
    step(2);
    expect_fast("fast_wait_third", mke(1, 0, 1, POR_CNT + 1));
    step(1);
    expect_fast("fast_rehold", mke(0, 0, 1, POR_CNT + 2));
    step(4);
    expect_fast("fast_rehold_last", mke(0, 0, 1, POR_CNT + 2));
    step(1);
    expect_fast("fast_wait2_first", mke(1, 0, 1, POR_CNT + 2));
    step(9);
    expect_fast("fast_wait2_last", mke(1, 0, 1, POR_CNT + 2));
    step(1);
    expect_fast("fast_ready", mke(1, 1, 0, POR_CNT + 2));
    step(20);
    expect_fast("fast_held_no_repeat", mke(1, 1, 0, POR_CNT + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
